// File: rtl/rr_arbiter_seq.sv
// Registered round-robin arbiter for N requesters with optional per-grant hold limit,
// software-loadable rotating priority pointer and a registered request popcount.
module rr_arbiter_seq #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 0,
    parameter int IW       = (N > 1) ? $clog2(N) : 1,
    parameter int CW       = $clog2(N + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  reqs_i,
    input  logic          ptr_load_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grants_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          any_grant_o,
    output logic [CW-1:0] cnt_o,
    output logic [IW-1:0] ptr_o
);

    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    // With HOLD_MAX == 0 the limit is never consulted, so any non-zero value keeps the compare honest.
    localparam logic [HW-1:0] HOLD_LIM = HW'((HOLD_MAX > 0) ? HOLD_MAX : 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        state_r, state_s;
    logic [N-1:0]  grants_r, grants_s;
    logic [IW-1:0] grant_idx_r, grant_idx_s;
    logic          any_grant_r, any_grant_s;
    logic [CW-1:0] cnt_r;
    logic [IW-1:0] ptr_r, ptr_s;
    logic [HW-1:0] hold_r, hold_s;
    logic [IW:0]   idle_pick_s, rel_pick_s;
    logic [IW-1:0] rel_ptr_s;
    logic          hold_done_s, keep_s, release_s;

    // First set bit of req scanning start, start+1, .., N-1, 0, .., start-1; MSB = found.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] req, input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] win;
        int            idx;
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < N; off++) begin
            idx = int'(start) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) begin
            c = c + CW'(v[k]);
        end
        return c;
    endfunction

    assign rel_ptr_s   = (grant_idx_r == IW'(N - 1)) ? '0 : grant_idx_r + IW'(1);
    assign idle_pick_s = rr_pick(reqs_i, ptr_r);
    assign rel_pick_s  = rr_pick(reqs_i & ~grants_r, rel_ptr_s);
    assign hold_done_s = (HOLD_MAX != 0) && (hold_r == HOLD_LIM);
    assign keep_s      = (|(reqs_i & grants_r)) && !hold_done_s;

    // Next-state, winner selection and hold counter update.
    always_comb begin
        state_s     = state_r;
        grant_idx_s = grant_idx_r;
        hold_s      = hold_r;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (idle_pick_s[IW]) begin
                    state_s     = ST_GRANT;
                    grant_idx_s = idle_pick_s[IW-1:0];
                    hold_s      = HW'(1);
                end else begin
                    state_s     = ST_IDLE;
                    grant_idx_s = '0;
                    hold_s      = '0;
                end
            end
            ST_GRANT: begin
                if (keep_s) begin
                    hold_s = hold_r + HW'(1);
                end else begin
                    release_s = 1'b1;
                    // Hand over without a bubble when anyone other than the old winner is waiting.
                    if (rel_pick_s[IW]) begin
                        grant_idx_s = rel_pick_s[IW-1:0];
                        hold_s      = HW'(1);
                    end else begin
                        state_s     = ST_IDLE;
                        grant_idx_s = '0;
                        hold_s      = '0;
                    end
                end
            end
            default: begin
                state_s     = ST_IDLE;
                grant_idx_s = '0;
                hold_s      = '0;
            end
        endcase
    end

    // Pointer update: a software load takes precedence over the release rotation.
    always_comb begin
        ptr_s = ptr_r;
        if (ptr_load_i) begin
            ptr_s = (int'(ptr_i) < N) ? ptr_i : '0;
        end else if (release_s) begin
            ptr_s = rel_ptr_s;
        end else begin
            ptr_s = ptr_r;
        end
    end

    // One-hot grant vector derived from the next winner.
    always_comb begin
        grants_s = '0;
        for (int k = 0; k < N; k++) begin
            grants_s[k] = (state_s == ST_GRANT) && (grant_idx_s == IW'(k));
        end
        any_grant_s = (state_s == ST_GRANT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            grants_r    <= '0;
            grant_idx_r <= '0;
            any_grant_r <= 1'b0;
            cnt_r       <= '0;
            ptr_r       <= '0;
            hold_r      <= '0;
        end else begin
            state_r     <= state_s;
            grants_r    <= grants_s;
            grant_idx_r <= grant_idx_s;
            any_grant_r <= any_grant_s;
            cnt_r       <= popcount(reqs_i);
            ptr_r       <= ptr_s;
            hold_r      <= hold_s;
        end
    end

    assign grants_o    = grants_r;
    assign grant_idx_o = grant_idx_r;
    assign any_grant_o = any_grant_r;
    assign cnt_o       = cnt_r;
    assign ptr_o       = ptr_r;

endmodule

// File: tb/tb_rr_arbiter_seq.sv
// Scoreboard bench for rr_arbiter_seq: N=8 unlimited hold, N=8 hold limit 3, N=5 and N=1.
module tb_rr_arbiter_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // N=8, HOLD_MAX=0
    logic [7:0] r8;  logic l8;  logic [2:0] p8;
    logic [7:0] g8;  logic [2:0] gi8; logic a8; logic [3:0] c8; logic [2:0] po8;
    // N=8, HOLD_MAX=3
    logic [7:0] rh;  logic lh;  logic [2:0] ph;
    logic [7:0] gh;  logic [2:0] gih; logic ah; logic [3:0] ch; logic [2:0] poh;
    // N=5
    logic [4:0] r5;  logic l5;  logic [2:0] p5;
    logic [4:0] g5;  logic [2:0] gi5; logic a5; logic [2:0] c5; logic [2:0] po5;
    // N=1
    logic [0:0] r1;  logic l1;  logic [0:0] p1;
    logic [0:0] g1;  logic [0:0] gi1; logic a1; logic [0:0] c1; logic [0:0] po1;

    rr_arbiter_seq #(.N(8), .HOLD_MAX(0)) u8 (
        .clk_i(clk), .rst_i(rst), .reqs_i(r8), .ptr_load_i(l8), .ptr_i(p8),
        .grants_o(g8), .grant_idx_o(gi8), .any_grant_o(a8), .cnt_o(c8), .ptr_o(po8));
    rr_arbiter_seq #(.N(8), .HOLD_MAX(3)) u8h (
        .clk_i(clk), .rst_i(rst), .reqs_i(rh), .ptr_load_i(lh), .ptr_i(ph),
        .grants_o(gh), .grant_idx_o(gih), .any_grant_o(ah), .cnt_o(ch), .ptr_o(poh));
    rr_arbiter_seq #(.N(5), .HOLD_MAX(0)) u5 (
        .clk_i(clk), .rst_i(rst), .reqs_i(r5), .ptr_load_i(l5), .ptr_i(p5),
        .grants_o(g5), .grant_idx_o(gi5), .any_grant_o(a5), .cnt_o(c5), .ptr_o(po5));
    rr_arbiter_seq #(.N(1), .HOLD_MAX(0)) u1 (
        .clk_i(clk), .rst_i(rst), .reqs_i(r1), .ptr_load_i(l1), .ptr_i(p1),
        .grants_o(g1), .grant_idx_o(gi1), .any_grant_o(a1), .cnt_o(c1), .ptr_o(po1));

    typedef struct packed { logic [7:0] gnt; logic [2:0] ptr; } e8_t;
    typedef struct packed { logic [4:0] gnt; logic [2:0] ptr; } e5_t;
    e8_t        q8[$];
    e5_t        q5[$];
    logic [3:0] qc8[$];
    logic [3:0] qch[$];
    logic [0:0] q1[$];

    task automatic clear_inputs();
        r8 = 8'h00; l8 = 1'b0; p8 = 3'd0;
        rh = 8'h00; lh = 1'b0; ph = 3'd0;
        r5 = 5'h00; l5 = 1'b0; p5 = 3'd0;
        r1 = 1'b0;  l1 = 1'b0; p1 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        e8_t e;
        rst = 1'b1;
        clear_inputs();
        r8 = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (g8 !== 8'h00)  begin failures++; $display("FAIL reset_grants got=%h exp=00", g8); end
        if (gi8 !== 3'd0)  begin failures++; $display("FAIL reset_idx got=%0d exp=0", gi8); end
        if (a8 !== 1'b0)   begin failures++; $display("FAIL reset_any got=%b exp=0", a8); end
        if (c8 !== 4'd0)   begin failures++; $display("FAIL reset_cnt got=%0d exp=0", c8); end
        if (po8 !== 3'd0)  begin failures++; $display("FAIL reset_ptr got=%0d exp=0", po8); end
        rst = 1'b0;
        q8.push_back({8'h01, 3'd0});
        qc8.push_back(4'd8);
        @(posedge clk);
        #1;
        e = q8.pop_front();
        checks += 4;
        if (g8 !== e.gnt)         begin failures++; $display("FAIL first_grant got=%h exp=%h", g8, e.gnt); end
        if (gi8 !== 3'd0)         begin failures++; $display("FAIL first_idx got=%0d exp=0", gi8); end
        if (a8 !== 1'b1)          begin failures++; $display("FAIL first_any got=%b exp=1", a8); end
        if (c8 !== qc8.pop_front()) begin failures++; $display("FAIL first_cnt got=%0d exp=8", c8); end
    endtask

    task automatic test_rotation();
        logic [7:0] rq [7];
        logic [7:0] eg [7];
        logic [2:0] ep [7];
        e8_t e;
        rq = '{8'h85, 8'h85, 8'h84, 8'h84, 8'h80, 8'h80, 8'h00};
        eg = '{8'h01, 8'h01, 8'h04, 8'h04, 8'h80, 8'h80, 8'h00};
        ep = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd3, 3'd3, 3'd0};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            r8 = rq[i];
            q8.push_back({eg[i], ep[i]});
            @(posedge clk);
            #1;
            e = q8.pop_front();
            checks += 3;
            if (g8 !== e.gnt)   begin failures++; $display("FAIL rot_grant[%0d] got=%h exp=%h", i, g8, e.gnt); end
            if (po8 !== e.ptr)  begin failures++; $display("FAIL rot_ptr[%0d] got=%0d exp=%0d", i, po8, e.ptr); end
            if (a8 !== |e.gnt)  begin failures++; $display("FAIL rot_any[%0d] got=%b exp=%b", i, a8, |e.gnt); end
        end
    endtask

    task automatic test_hold_limit();
        e8_t e;
        logic [7:0] eg;
        logic [2:0] ep;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            rh = 8'h12;
            eg = (((i / 3) % 2) == 0) ? 8'h02 : 8'h10;
            ep = (i < 3) ? 3'd0 : ((((i / 3) % 2) == 1) ? 3'd2 : 3'd5);
            q8.push_back({eg, ep});
            @(posedge clk);
            #1;
            e = q8.pop_front();
            checks += 2;
            if (gh !== e.gnt)  begin failures++; $display("FAIL hold_grant[%0d] got=%h exp=%h", i, gh, e.gnt); end
            if (poh !== e.ptr) begin failures++; $display("FAIL hold_ptr[%0d] got=%0d exp=%0d", i, poh, e.ptr); end
        end
        // Sole requester: one idle cycle after each expiry.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rh = 8'h02;
            eg = ((i % 4) == 3) ? 8'h00 : 8'h02;
            ep = (i < 3) ? 3'd0 : 3'd2;
            q8.push_back({eg, ep});
            @(posedge clk);
            #1;
            e = q8.pop_front();
            checks += 2;
            if (gh !== e.gnt)  begin failures++; $display("FAIL sole_grant[%0d] got=%h exp=%h", i, gh, e.gnt); end
            if (poh !== e.ptr) begin failures++; $display("FAIL sole_ptr[%0d] got=%0d exp=%0d", i, poh, e.ptr); end
        end
    endtask

    task automatic test_ptr_load();
        logic [7:0] rq [5];
        logic       ld [5];
        logic [2:0] pv [5];
        logic [7:0] eg [5];
        logic [2:0] ep [5];
        logic [2:0] p5v [4];
        logic [2:0] p5e [4];
        e8_t e;
        e5_t f;
        rq = '{8'h00, 8'h43, 8'h03, 8'h02, 8'h00};
        ld = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        pv = '{3'd5, 3'd0, 3'd0, 3'd0, 3'd0};
        eg = '{8'h00, 8'h40, 8'h01, 8'h02, 8'h00};
        ep = '{3'd5, 3'd5, 3'd7, 3'd1, 3'd2};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r8 = rq[i]; l8 = ld[i]; p8 = pv[i];
            q8.push_back({eg[i], ep[i]});
            @(posedge clk);
            #1;
            e = q8.pop_front();
            checks += 2;
            if (g8 !== e.gnt)  begin failures++; $display("FAIL load_grant[%0d] got=%h exp=%h", i, g8, e.gnt); end
            if (po8 !== e.ptr) begin failures++; $display("FAIL load_ptr[%0d] got=%0d exp=%0d", i, po8, e.ptr); end
        end
        l8 = 1'b0;
        // Out-of-range pointer values on N=5 fall back to 0.
        p5v = '{3'd3, 3'd5, 3'd3, 3'd7};
        p5e = '{3'd3, 3'd0, 3'd3, 3'd0};
        for (int i = 0; i < 4; i++) begin
            l5 = 1'b1; p5 = p5v[i];
            q5.push_back({5'h00, p5e[i]});
            @(posedge clk);
            #1;
            f = q5.pop_front();
            checks += 2;
            if (po5 !== f.ptr) begin failures++; $display("FAIL load5_ptr[%0d] got=%0d exp=%0d", i, po5, f.ptr); end
            if (g5 !== f.gnt)  begin failures++; $display("FAIL load5_grant[%0d] got=%h exp=%h", i, g5, f.gnt); end
        end
        l5 = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] rq [7];
        logic       ld [7];
        logic [2:0] pv [7];
        logic [7:0] eg [7];
        logic [2:0] ep [7];
        logic [2:0] ei;
        e8_t e;
        rq = '{8'h98, 8'h90, 8'h90, 8'h80, 8'h00, 8'h21, 8'h00};
        ld = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        pv = '{3'd0, 3'd6, 3'd2, 3'd0, 3'd0, 3'd4, 3'd0};
        eg = '{8'h08, 8'h10, 8'h10, 8'h80, 8'h00, 8'h01, 8'h00};
        ep = '{3'd0, 3'd6, 3'd2, 3'd5, 3'd0, 3'd4, 3'd1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            r8 = rq[i]; l8 = ld[i]; p8 = pv[i];
            q8.push_back({eg[i], ep[i]});
            @(posedge clk);
            #1;
            e = q8.pop_front();
            ei = 3'd0;
            for (int k = 0; k < 8; k++) begin
                if (e.gnt[k]) ei = 3'(k);
            end
            checks += 3;
            if (g8 !== e.gnt)  begin failures++; $display("FAIL simul_grant[%0d] got=%h exp=%h", i, g8, e.gnt); end
            if (po8 !== e.ptr) begin failures++; $display("FAIL simul_ptr[%0d] got=%0d exp=%0d", i, po8, e.ptr); end
            if (gi8 !== ei)    begin failures++; $display("FAIL simul_idx[%0d] got=%0d exp=%0d", i, gi8, ei); end
        end
        l8 = 1'b0;
    endtask

    task automatic test_edge_sizes();
        logic [0:0] rq1 [3];
        logic [4:0] rq5 [5];
        logic [4:0] eg5 [5];
        logic [2:0] ep5 [5];
        logic [2:0] ei5;
        logic [0:0] e1;
        e5_t f;
        rq1 = '{1'b1, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            r1 = rq1[i];
            q1.push_back(rq1[i]);
            @(posedge clk);
            #1;
            e1 = q1.pop_front();
            checks += 4;
            if (g1 !== e1)   begin failures++; $display("FAIL n1_grant[%0d] got=%b exp=%b", i, g1, e1); end
            if (a1 !== e1)   begin failures++; $display("FAIL n1_any[%0d] got=%b exp=%b", i, a1, e1); end
            if (c1 !== e1)   begin failures++; $display("FAIL n1_cnt[%0d] got=%0d exp=%0d", i, c1, e1); end
            if (po1 !== 1'b0) begin failures++; $display("FAIL n1_ptr[%0d] got=%0d exp=0", i, po1); end
        end
        rq5 = '{5'b10001, 5'b10000, 5'b00001, 5'b10000, 5'b00001};
        eg5 = '{5'b00001, 5'b10000, 5'b00001, 5'b10000, 5'b00001};
        ep5 = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            r5 = rq5[i];
            q5.push_back({eg5[i], ep5[i]});
            @(posedge clk);
            #1;
            f = q5.pop_front();
            ei5 = f.gnt[4] ? 3'd4 : 3'd0;
            checks += 3;
            if (g5 !== f.gnt)  begin failures++; $display("FAIL n5_grant[%0d] got=%b exp=%b", i, g5, f.gnt); end
            if (gi5 !== ei5)   begin failures++; $display("FAIL n5_idx[%0d] got=%0d exp=%0d", i, gi5, ei5); end
            if (po5 !== f.ptr) begin failures++; $display("FAIL n5_ptr[%0d] got=%0d exp=%0d", i, po5, f.ptr); end
        end
    endtask

    task automatic test_random();
        logic [7:0] prev8, prevh;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            r8 = 8'($urandom);
            rh = 8'($urandom);
            l8 = ($urandom_range(0, 15) == 0);
            p8 = 3'($urandom);
            prev8 = r8;
            prevh = rh;
            qc8.push_back(4'($countones(r8)));
            qch.push_back(4'($countones(rh)));
            @(posedge clk);
            #1;
            checks += 10;
            if (c8 !== qc8.pop_front()) begin failures++; $display("FAIL rnd_cnt8[%0d] got=%0d exp=%0d", i, c8, $countones(prev8)); end
            if (ch !== qch.pop_front()) begin failures++; $display("FAIL rnd_cnth[%0d] got=%0d exp=%0d", i, ch, $countones(prevh)); end
            if (!$onehot0(g8)) begin failures++; $display("FAIL rnd_onehot8[%0d] got=%h exp=onehot0", i, g8); end
            if (!$onehot0(gh)) begin failures++; $display("FAIL rnd_onehoth[%0d] got=%h exp=onehot0", i, gh); end
            if (a8 !== |g8)    begin failures++; $display("FAIL rnd_any8[%0d] got=%b exp=%b", i, a8, |g8); end
            if (ah !== |gh)    begin failures++; $display("FAIL rnd_anyh[%0d] got=%b exp=%b", i, ah, |gh); end
            if (a8 && (g8[gi8] !== 1'b1)) begin failures++; $display("FAIL rnd_idx8[%0d] got=%h idx=%0d", i, g8, gi8); end
            if (ah && (gh[gih] !== 1'b1)) begin failures++; $display("FAIL rnd_idxh[%0d] got=%h idx=%0d", i, gh, gih); end
            if ((g8 & ~prev8) !== 8'h00) begin failures++; $display("FAIL rnd_noreq8[%0d] got=%h exp_subset_of=%h", i, g8, prev8); end
            if ((gh & ~prevh) !== 8'h00) begin failures++; $display("FAIL rnd_noreqh[%0d] got=%h exp_subset_of=%h", i, gh, prevh); end
        end
        l8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold_limit();
        test_ptr_load();
        test_simultaneous();
        test_edge_sizes();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
